sram_arbiter: RTL

Shares the 64-bit external SRAM pair (two 32-bit chips, common address, shared bidirectional data bus) between a write requester (init stream) and a read requester (primitive/edge-mask lookup). Sequences read/write direction changes, inserts bus turnaround, drains in-flight reads before writing, and bounds starvation with a burst limit. Sits between `sram_init` / lookup logic and the `perip_SRAM` pin drivers; the top-level tristate is steered by `sram_mode`.

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_rd_pipe.sv | 42 ++++
 rtl/sram_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the external SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDrain,
    StTurn
  } arb_state_e;

  // sram_mode encoding: read releases the bus, write drives it.
  localparam logic MODE_READ  = 1'b1;
  localparam logic MODE_WRITE = 1'b0;

  localparam int unsigned DefaultMaxBurst = 8;
  localparam logic [7:0]  BurstSat        = 8'hFF;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read return pipe: tracks reads in flight and captures bus data when it lands.
module sram_rd_pipe #(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned DATAW  = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             issue,
  input  logic [DATAW-1:0] sram_rdata,
  output logic             rd_valid,
  output logic [DATAW-1:0] rd_data,
  output logic             busy
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] valid_d;
  logic [DATAW-1:0]  data_q;

  // Shift the in-flight marker one stage per cycle.
  always_comb begin
    valid_d = (valid_q << 1) | RD_LAT'(issue);
  end

  // Advance the pipe; latch bus data on the cycle its valid reaches the last stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (valid_d[RD_LAT-1]) begin
        data_q <= sram_rdata;
      end
    end
  end

  assign rd_valid = valid_q[RD_LAT-1];
  assign rd_data  = data_q;
  // Read pins active this cycle also count as in flight.
  assign busy     = issue | (|valid_q);

endmodule

// File: rtl/sram_arbiter.sv
// Shares the external SRAM pair between a write stream and a read stream.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDRW     = 19,
  parameter int unsigned DATAW     = 64,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned MAX_BURST = DefaultMaxBurst
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_req,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [DATAW-1:0] wr_data,
  output logic             wr_gnt,
  input  logic             wr_prio,
  input  logic             rd_req,
  input  logic [ADDRW-1:0] rd_addr,
  output logic             rd_gnt,
  output logic             rd_valid,
  output logic [DATAW-1:0] rd_data,
  output logic             sram_mode,
  output logic [1:0]       sram_cs_n,
  output logic [1:0]       sram_wr_n,
  output logic [ADDRW-1:0] sram_addr,
  output logic [DATAW-1:0] sram_wdata,
  input  logic [DATAW-1:0] sram_rdata
);

  localparam logic [7:0] BurstLimit = 8'(MAX_BURST);

  arb_state_e       state_q;
  logic             mode_q;
  logic [7:0]       burst_q;
  logic [1:0]       cs_n_q;
  logic [1:0]       wr_n_q;
  logic [ADDRW-1:0] addr_q;
  logic [DATAW-1:0] wdata_q;
  logic             rd_issue_q;
  logic             pipe_busy;

  logic any_req;
  logic win_dir;
  logic can_grant;

  // Pick the side that should own the bus and grant it if already facing that way.
  always_comb begin
    any_req = wr_req | rd_req;
    win_dir = mode_q;
    if (wr_req && (wr_prio || !rd_req)) begin
      win_dir = MODE_WRITE;
    end else if (rd_req && !wr_req) begin
      win_dir = MODE_READ;
    end else if (wr_req && rd_req && (burst_q >= BurstLimit)) begin
      // >= rather than ==: uncontested runs keep counting past the limit.
      win_dir = ~mode_q;
    end
    can_grant = !RST && any_req && ((state_q == StIdle) || (state_q == StAccess)) &&
                (win_dir == mode_q);
    wr_gnt = can_grant && (win_dir == MODE_WRITE);
    rd_gnt = can_grant && (win_dir == MODE_READ);
  end

  // Direction FSM plus registered pin drive.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      mode_q     <= MODE_READ;
      burst_q    <= '0;
      cs_n_q     <= 2'b11;
      wr_n_q     <= 2'b11;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_issue_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAccess: begin
          if (!any_req) begin
            state_q <= StIdle;
          end else if (can_grant) begin
            state_q <= StAccess;
            if (burst_q != BurstSat) begin
              burst_q <= burst_q + 8'd1;
            end
          end else begin
            state_q <= pipe_busy ? StDrain : StTurn;
          end
        end
        StDrain: begin
          if (!pipe_busy) begin
            state_q <= StTurn;
          end
        end
        StTurn: begin
          // Committed to the flip; re-evaluate selection from idle next cycle.
          mode_q  <= ~mode_q;
          burst_q <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (wr_gnt) begin
        cs_n_q  <= 2'b00;
        wr_n_q  <= 2'b00;
        addr_q  <= wr_addr;
        wdata_q <= wr_data;
      end else if (rd_gnt) begin
        cs_n_q <= 2'b00;
        wr_n_q <= 2'b11;
        addr_q <= rd_addr;
      end else begin
        cs_n_q <= 2'b11;
        wr_n_q <= 2'b11;
      end
      rd_issue_q <= rd_gnt;
    end
  end

  sram_rd_pipe #(
    .RD_LAT (RD_LAT),
    .DATAW  (DATAW)
  ) u_rd_pipe (
    .CLK        (CLK),
    .RST        (RST),
    .issue      (rd_issue_q),
    .sram_rdata (sram_rdata),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .busy       (pipe_busy)
  );

  assign sram_mode  = mode_q;
  assign sram_cs_n  = cs_n_q;
  assign sram_wr_n  = wr_n_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule
